// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the modular exponentiator.
// Optional build macro: MOD_EXP_LADDER_DUAL_MUL_EN (dual-multiplier ladder).
package mod_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LADDER_A,
    LADDER_B,
    FIN
  } state_e;

  // 2^255 - 19
  localparam logic [254:0] P25519 = {{250{1'b1}}, 5'b01101};

  // Cycles from the start-sampling edge to the done-high edge for valid operands.
  function automatic int unsigned mod_exp_lat(input int unsigned n,
                                              input int unsigned kw,
                                              input bit          dual);
    return 2 + (dual ? 1 : 2) * kw * (n + 2);
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Iterative MSB-first shift-add modular multiplier: y = a*b mod p.
// Fixed N+1 cycles from start to done; operands must be < p.
module mod_mul #(
  parameter int unsigned N = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] p,
  output logic         done,
  output logic [N-1:0] y
);
  localparam int unsigned CW = $clog2(N + 1);

  logic [N-1:0]  a_q, b_q, p_q;
  logic [N:0]    acc_q, acc_d;
  logic [N:0]    pe, dbl_raw, dbl, sum_raw;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  // Both partial results stay below 2p, so one conditional subtract each suffices.
  always_comb begin
    pe      = {1'b0, p_q};
    dbl_raw = acc_q << 1;
    dbl     = (dbl_raw >= pe) ? (dbl_raw - pe) : dbl_raw;
    sum_raw = dbl + (b_q[N-1] ? {1'b0, a_q} : '0);
    acc_d   = (sum_raw >= pe) ? (sum_raw - pe) : sum_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      p_q    <= p;
      acc_q  <= '0;
      cnt_q  <= CW'(N);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      acc_q  <= acc_d;
      b_q    <= b_q << 1;
      cnt_q  <= cnt_q - CW'(1);
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign y    = acc_q[N-1:0];

endmodule

// File: rtl/mod_exp_ladder.sv
// Constant-time Montgomery-ladder modular exponentiator: result = x^k mod p.
// Define MOD_EXP_LADDER_DUAL_MUL_EN to run both ladder products concurrently.
module mod_exp_ladder
  import mod_exp_pkg::*;
#(
  parameter int unsigned N  = 255,
  parameter int unsigned KW = N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  x,
  input  logic [KW-1:0] k,
  input  logic [N-1:0]  p,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [N-1:0]  result
);
  localparam int unsigned IW = (KW > 1) ? $clog2(KW) : 1;
`ifdef MOD_EXP_LADDER_DUAL_MUL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [N-1:0]  x_q, x_d, p_q, p_d, r0_q, r0_d, r1_q, r1_d;
  logic [KW-1:0] k_q, k_d;
  logic [IW-1:0] i_q, i_d;
  logic          inv_q, inv_d, issue_q, issue_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N-1:0]  result_q, result_d;
  logic          kb;
  logic [N-1:0]  sq;
  logic [N-1:0]  my0;
  logic          md0;

  assign kb = k_q[i_q];
  assign sq = kb ? r1_q : r0_q;

`ifdef MOD_EXP_LADDER_DUAL_MUL_EN
  logic [N-1:0] my1;
  logic         md1;

  mod_mul #(.N(N)) u_mul_x (
    .clk(clk), .rst_n(rst_n), .start(issue_q),
    .a(r0_q), .b(r1_q), .p(p_q), .done(md0), .y(my0)
  );
  mod_mul #(.N(N)) u_mul_sq (
    .clk(clk), .rst_n(rst_n), .start(issue_q),
    .a(sq), .b(sq), .p(p_q), .done(md1), .y(my1)
  );
`else
  logic [N-1:0] tmp_q, tmp_d;
  logic [N-1:0] ma, mb;
  logic         in_b;

  assign in_b = (state_q == LADDER_B);
  assign ma   = in_b ? sq : r0_q;
  assign mb   = in_b ? sq : r1_q;

  mod_mul #(.N(N)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(issue_q),
    .a(ma), .b(mb), .p(p_q), .done(md0), .y(my0)
  );
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    k_d      = k_q;
    p_d      = p_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    i_d      = i_q;
    inv_d    = inv_q;
    issue_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
`ifndef MOD_EXP_LADDER_DUAL_MUL_EN
    tmp_d    = tmp_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          x_d     = x;
          k_d     = k;
          p_d     = p;
          inv_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!p_q[0] || (p_q < N'(3)) || (x_q >= p_q)) begin
          inv_d   = 1'b1;
          state_d = FIN;
        end else begin
          r0_d    = N'(1);
          r1_d    = x_q;
          i_d     = IW'(KW - 1);
          issue_d = 1'b1;
          state_d = LADDER_A;
        end
      end
`ifdef MOD_EXP_LADDER_DUAL_MUL_EN
      LADDER_A: begin
        if (md0 && md1) begin
          r0_d = kb ? my0 : my1;
          r1_d = kb ? my1 : my0;
          if (i_q == '0) begin
            state_d = FIN;
          end else begin
            i_d     = i_q - IW'(1);
            issue_d = 1'b1;
          end
        end
      end
`else
      LADDER_A: begin
        if (md0) begin
          tmp_d   = my0;
          issue_d = 1'b1;
          state_d = LADDER_B;
        end
      end
      // Cross product from LADDER_A is committed together with the square.
      LADDER_B: begin
        if (md0) begin
          r0_d = kb ? tmp_q : my0;
          r1_d = kb ? my0 : tmp_q;
          if (i_q == '0) begin
            state_d = FIN;
          end else begin
            i_d     = i_q - IW'(1);
            issue_d = 1'b1;
            state_d = LADDER_A;
          end
        end
      end
`endif
      FIN: begin
        result_d = inv_q ? '0 : r0_q;
        err_d    = inv_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      k_q      <= '0;
      p_q      <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      i_q      <= '0;
      inv_q    <= 1'b0;
      issue_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifndef MOD_EXP_LADDER_DUAL_MUL_EN
      tmp_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      k_q      <= k_d;
      p_q      <= p_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      i_q      <= i_d;
      inv_q    <= inv_d;
      issue_q  <= issue_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifndef MOD_EXP_LADDER_DUAL_MUL_EN
      tmp_q    <= tmp_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

`ifndef SYNTHESIS
  int unsigned lat_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q <= '0;
    end else begin
      lat_cnt_q <= (state_q == IDLE) ? 1 : lat_cnt_q + 1;
      if (state_q == FIN)
        assert (lat_cnt_q == (inv_q ? 2 : mod_exp_lat(N, KW, DUAL)));
    end
  end
`endif

endmodule

// File: tb/tb_mod_exp_ladder.sv
// Directed bench for mod_exp_ladder: an 8-bit instance for function and handshake,
// plus a 255-bit instance over P25519 exercising wide reduction.
module tb_mod_exp_ladder;
  import mod_exp_pkg::*;

`ifdef MOD_EXP_LADDER_DUAL_MUL_EN
  localparam int unsigned LAT8 = 82;
  localparam int unsigned LATW = 2058;
`else
  localparam int unsigned LAT8 = 162;
  localparam int unsigned LATW = 4114;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start8, busy8, done8, err8;
  logic [7:0]   x8, k8, p8, res8;
  logic         startw, busyw, donew, errw;
  logic [254:0] xw, pw, resw;
  logic [7:0]   kw;

  int checks = 0;
  int errors = 0;

  mod_exp_ladder #(.N(8), .KW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .k(k8), .p(p8),
    .busy(busy8), .done(done8), .err(err8), .result(res8)
  );

  mod_exp_ladder #(.N(255), .KW(8)) dutw (
    .clk(clk), .rst_n(rst_n), .start(startw), .x(xw), .k(kw), .p(pw),
    .busy(busyw), .done(donew), .err(errw), .result(resw)
  );

  task automatic run8(input logic [7:0] xv, input logic [7:0] kv, input logic [7:0] pv,
                      output int unsigned lat, output logic [7:0] res, output logic e);
    repeat (2) @(negedge clk);
    x8 = xv; k8 = kv; p8 = pv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!done8) begin
      errors++;
      $display("FAIL run8_timeout: no done after %0d cycles, expected within 1000", lat);
    end
    res = res8;
    e   = err8;
  endtask

  task automatic runw(input logic [254:0] xv, input logic [7:0] kv,
                      output int unsigned lat, output logic [254:0] res, output logic e);
    repeat (2) @(negedge clk);
    xw = xv; kw = kv; pw = P25519; startw = 1'b1;
    @(posedge clk); #1;
    startw = 1'b0;
    lat = 0;
    while (!donew && lat < 10000) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!donew) begin
      errors++;
      $display("FAIL runw_timeout: no done after %0d cycles, expected within 10000", lat);
    end
    res = resw;
    e   = errw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; x8 = '0; k8 = '0; p8 = '0;
    startw = 1'b0; xw = '0; kw = '0; pw = '0;
    #1;
    checks++;
    if ({busy8, done8, err8} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags8: got %b, expected 000", {busy8, done8, err8});
    end
    checks++;
    if (res8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_result8: got %0d, expected 0", res8);
    end
    checks++;
    if ({busyw, donew, errw} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flagsw: got %b, expected 000", {busyw, donew, errw});
    end
    checks++;
    if (resw !== 255'd0) begin
      errors++;
      $display("FAIL reset_resultw: got %h, expected 0", resw);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int unsigned lat;
    logic [7:0]  res;
    logic        e;
    run8(8'd5, 8'd12, 8'd251, lat, res, e);
    checks++;
    if (res !== 8'd204) begin
      errors++;
      $display("FAIL basic_result: got %0d, expected 204", res);
    end
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %b, expected 0", e);
    end
    checks++;
    if (lat !== LAT8) begin
      errors++;
      $display("FAIL basic_latency: got %0d, expected %0d", lat, LAT8);
    end
    // start presented during the done cycle must be ignored
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b, expected 0", done8);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_cycle: got busy=%b, expected 0", busy8);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] xs [3] = '{8'd5, 8'd251, 8'd0};
    logic [7:0] ps [3] = '{8'd250, 8'd251, 8'd1};
    int unsigned lat;
    logic [7:0]  res;
    logic        e;
    for (int i = 0; i < 3; i++) begin
      run8(xs[i], 8'd12, ps[i], lat, res, e);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL invalid%0d_latency: got %0d, expected 2", i, lat);
      end
      checks++;
      if (e !== 1'b1) begin
        errors++;
        $display("FAIL invalid%0d_err: got %b, expected 1", i, e);
      end
      checks++;
      if (res !== 8'd0) begin
        errors++;
        $display("FAIL invalid%0d_result: got %0d, expected 0", i, res);
      end
    end
  endtask

  task automatic test_special();
    logic [7:0] xs [4] = '{8'd3, 8'd3, 8'd0, 8'd250};
    logic [7:0] ks [4] = '{8'd250, 8'd0, 8'd7, 8'd1};
    logic [7:0] ex [4] = '{8'd1, 8'd1, 8'd0, 8'd250};
    int unsigned lat;
    logic [7:0]  res;
    logic        e;
    for (int i = 0; i < 4; i++) begin
      run8(xs[i], ks[i], 8'd251, lat, res, e);
      checks++;
      if (res !== ex[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL special%0d: got result=%0d err=%b, expected result=%0d err=0",
                 i, res, e, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned cyc, ndone, first, busy_bad;
    logic [7:0]  res;
    repeat (2) @(negedge clk);
    x8 = 8'd5; k8 = 8'd12; p8 = 8'd251; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0; ndone = 0; first = 0; busy_bad = 0; res = '0;
    while (cyc < 400) begin
      if (cyc == 20) begin start8 = 1'b1; x8 = 8'd7; k8 = 8'd99; end
      if (cyc == 21) begin start8 = 1'b0; p8 = 8'd250; end
      @(posedge clk); #1;
      cyc++;
      if (done8) begin
        ndone++;
        if (first == 0) begin first = cyc; res = res8; end
      end else if (ndone == 0 && !busy8) begin
        busy_bad++;
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d, expected 1", ndone);
    end
    checks++;
    if (first !== LAT8) begin
      errors++;
      $display("FAIL restart_latency: got %0d, expected %0d", first, LAT8);
    end
    checks++;
    if (res !== 8'd204) begin
      errors++;
      $display("FAIL restart_result: got %0d, expected 204", res);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL restart_busy: got %0d low-busy cycles, expected 0", busy_bad);
    end
  endtask

  task automatic test_reset_abort();
    int unsigned ndone, lat;
    logic [7:0]  res;
    logic        e;
    repeat (2) @(negedge clk);
    x8 = 8'd5; k8 = 8'd12; p8 = 8'd251; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, err8} !== 3'b000 || res8 !== 8'd0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b err=%b result=%0d, expected all 0",
               busy8, done8, err8, res8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", ndone);
    end
    run8(8'd5, 8'd12, 8'd251, lat, res, e);
    checks++;
    if (res !== 8'd204 || e !== 1'b0) begin
      errors++;
      $display("FAIL abort_rerun_result: got %0d err=%b, expected 204 err=0", res, e);
    end
    checks++;
    if (lat !== LAT8) begin
      errors++;
      $display("FAIL abort_rerun_latency: got %0d, expected %0d", lat, LAT8);
    end
  endtask

  task automatic test_wide();
    logic [254:0] xv, ex, res;
    int unsigned  lat;
    logic         e;
    // (2^200)^2 = 2^145 * 2^255 == 19 * 2^145 (mod 2^255-19)
    xv = '0;
    xv[200] = 1'b1;
    ex = 255'(19) << 145;
    runw(xv, 8'd2, lat, res, e);
    checks++;
    if (res !== ex || e !== 1'b0) begin
      errors++;
      $display("FAIL wide_square: got %h err=%b, expected %h err=0", res, e, ex);
    end
    checks++;
    if (lat !== LATW) begin
      errors++;
      $display("FAIL wide_latency: got %0d, expected %0d", lat, LATW);
    end
    // (p-1)^3 == -1 == p-1
    xv = P25519 - 255'd1;
    runw(xv, 8'd3, lat, res, e);
    checks++;
    if (res !== xv || e !== 1'b0) begin
      errors++;
      $display("FAIL wide_minus_one: got %h err=%b, expected %h err=0", res, e, xv);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_special();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
